// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for the 5-stage MIPS core.
// Decides load/hold/bubble for PC, IF/ID, ID/EX and EX/MEM each cycle, sequences
// the multi-cycle mul/div unit and keeps a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rf_raddr0_ID,
   input  logic [4:0]  rf_raddr1_ID,
   input  logic        rs_used_ID,
   input  logic        rt_used_ID,
   input  logic        muldiv_req_ID,
   input  logic        hilo_use_ID,
   input  logic        rf_wen_EX,
   input  logic [4:0]  rf_waddr_EX,
   input  logic        mem_ren_EX,
   input  logic        muldiv_req_EX,
   input  logic        muldiv_div_EX,
   input  logic        branch_taken_EX,
   input  logic        mem_stall_MEM,
   input  logic        perf_clr,
   output logic        pc_wen,
   output logic        ifid_wen,
   output logic        ifid_flush,
   output logic        idex_wen,
   output logic        idex_flush,
   output logic        exmem_wen,
   output logic        muldiv_start,
   output logic        muldiv_is_div,
   output logic        muldiv_busy,
   output logic        muldiv_done,
   output logic [31:0] stall_cycles
);

   typedef enum logic {IDLE, BUSY} state_t;

   // Counter load values: the counter runs LAT-1 down to 0, one BUSY cycle per value.
   localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

   state_t      state_reg;
   logic [5:0]  cnt_reg;
   logic        busy_reg;
   logic        done_reg;
   logic [31:0] stall_reg;

   logic        load_use;
   logic        hilo_wait;
   logic        unfrozen;
   logic [5:0]  load_val;

   // Only the data-memory freeze holds EX/MEM, so this term has no dependence on
   // the mul/div start and the start/hilo_wait/wen chain stays loop-free.
   assign unfrozen      = ~mem_stall_MEM;
   assign muldiv_start  = muldiv_req_EX & unfrozen & (state_reg == IDLE);
   assign muldiv_is_div = muldiv_div_EX;
   assign load_val      = muldiv_div_EX ? DIV_LOAD : MUL_LOAD;

   assign load_use = mem_ren_EX & rf_wen_EX & (rf_waddr_EX != 5'd0) &
                     ((rs_used_ID & (rf_raddr0_ID == rf_waddr_EX)) |
                      (rt_used_ID & (rf_raddr1_ID == rf_waddr_EX)));

   // HI/LO consumers wait until the done cycle, when the result is written at its closing edge.
   assign hilo_wait = (hilo_use_ID | muldiv_req_ID) &
                      (muldiv_start | ((state_reg == BUSY) & (cnt_reg != 6'd0)));

   // Prioritised pipeline enables: freeze > taken-branch squash > ID stall > run.
   always_comb begin
      pc_wen     = 1'b1;
      ifid_wen   = 1'b1;
      idex_wen   = 1'b1;
      exmem_wen  = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (mem_stall_MEM) begin
         pc_wen    = 1'b0;
         ifid_wen  = 1'b0;
         idex_wen  = 1'b0;
         exmem_wen = 1'b0;
      end else if (branch_taken_EX) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use | hilo_wait) begin
         pc_wen     = 1'b0;
         ifid_wen   = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // Mul/div sequencer with registered busy/done flags; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 6'd0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (muldiv_start) begin
                  state_reg <= BUSY;
                  cnt_reg   <= load_val;
                  busy_reg  <= 1'b1;
                  done_reg  <= (load_val == 6'd0);
               end
            end
            BUSY: begin
               if (cnt_reg == 6'd0) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b0;
               end else begin
                  cnt_reg  <= cnt_reg - 6'd1;
                  done_reg <= (cnt_reg == 6'd1);
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign muldiv_busy = busy_reg;
   assign muldiv_done = done_reg;

   // Saturating count of cycles in which the PC did not advance; clear wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_reg <= 32'd0;
      end else if (perf_clr) begin
         stall_reg <= 32'd0;
      end else if (!pc_wen && (stall_reg != 32'hFFFF_FFFF)) begin
         stall_reg <= stall_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_reg;

endmodule
